ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-lite bus slave fronting a single-port synchronous SRAM; downstream consumer of the CPU memory access unit's bus transactions (HADDR/HTRANS/HWRITE/HSIZE/HWDATA).
- Returns HRDATA/HREADYOUT/HRESP to the master.
- Decodes size and byte lanes, inserts programmable wait states, and flags misaligned or out-of-range accesses with a two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address bits (capacity 4<<ADDR_WIDTH bytes).
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window; must be capacity-aligned.
- WAIT_STATES, 1, extra data-phase cycles, legal range 0..7.

Ports:
- HCLK  input  1  single clock; all logic on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from address decoder.
- HADDR  input  32  byte address (address phase).
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 write, 0 read.
- HSIZE  input  3  000 byte, 001 halfword, 010 word; others illegal.
- HBURST  input  3  ignored; only single transfers are issued.
- HWDATA  input  32  write data (data phase).
- HREADY  input  1  bus-wide ready; a transfer is sampled only when high.
- HREADYOUT  output  1  slave ready.
- HRDATA  output  32  read data.
- HRESP  output  2  00 OKAY, 01 ERROR.
- sram_cs  output  1  SRAM access strobe.
- sram_we  output  1  SRAM write enable (valid with sram_cs).
- sram_be  output  4  byte enables, bit i = byte lane i.
- sram_addr  output  ADDR_WIDTH  SRAM word address.
- sram_wdata  output  32  write data to SRAM.
- sram_rdata  input  32  SRAM read data, valid the cycle after a read strobe; held until the next read.

Behaviour:
- Reset: HRESET is synchronous and active-high. While it is high:
  - state goes to IDLE;
  - HREADYOUT=1, HRESP=00, HRDATA=0;
  - sram_cs=0 and sram_we=0, combinationally masked in the reset cycle;
  - any in-flight transfer is dropped and no SRAM write occurs.
- Accept: on the rising edge where HSEL&HREADY&HTRANS[1], latch HADDR, HWRITE, HSIZE. IDLE/BUSY or HSEL=0 transfers get zero-wait OKAY and change no state.
- Legality check at accept. A transfer is illegal if any of these hold:
  - HSIZE>010;
  - HSIZE=001 with HADDR[0]=1;
  - HSIZE=010 with HADDR[1:0]!=00;
  - HADDR-BASE_ADDR >= (4<<ADDR_WIDTH), computed as a 32-bit unsigned compare (addresses below base wrap to large values and are illegal).
- States: IDLE, WAIT, RD_ACC, WR_ACC, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=00.
    - Legal write, WAIT_STATES>0: go to WAIT; wait counter loaded with WAIT_STATES.
    - Legal write, WAIT_STATES=0: go to WR_ACC.
    - Legal read: go to WAIT with counter = max(WAIT_STATES,1) and issue the SRAM read in the first WAIT cycle.
    - Illegal: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=00; counter decrements each cycle. At 1 go to WR_ACC (write) or RD_ACC (read).
  - WR_ACC: final data-phase cycle. HREADYOUT=1, sram_cs=1, sram_we=1, sram_wdata=HWDATA, sram_be from the latched size/offset.
  - RD_ACC: final cycle. HREADYOUT=1, HRDATA=sram_rdata as the full word; the master selects lanes.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
  - No SRAM access in either ERR state.
- Read strobe: first WAIT cycle of a read. sram_cs=1, sram_we=0, sram_be=1111, sram_addr=latched word address.
- Byte enables (little-endian):
  - byte: 0001<<HADDR[1:0];
  - halfword: 0011<<(2*HADDR[1]);
  - word: 1111.
- sram_addr = (HADDR-BASE_ADDR)[ADDR_WIDTH+1:2].
- Data-phase length: writes WAIT_STATES+1 cycles; reads max(WAIT_STATES,1)+1 cycles; errors exactly 2 cycles.
- Pipelining: in WR_ACC, RD_ACC and ERR2 (HREADYOUT=1) a new address phase is sampled, with the same rules as IDLE, giving back-to-back transfers with no idle cycle. In all other states the address phase is ignored.
- Outside RD_ACC, HRDATA=0.
- SRAM is single-port. Read strobes never coincide with write strobes, because a read strobe always follows the previous write's data phase.

Test Plan:
- Reset: hold HRESET high 2 cycles with HSEL=1, HTRANS=10 -> HREADYOUT=1, HRESP=00, HRDATA=0, sram_cs=0 throughout; release -> next transfer accepted normally.
- Word write/read, WAIT_STATES=1: write 0x0000_0010, HWDATA=0xDEADBEEF.
  - Expect 1 wait cycle, then sram_cs=1, we=1, be=1111, sram_addr=4.
  - Read same address -> 1 wait cycle, then HRDATA=0xDEADBEEF, HRESP=00.
- Sub-word: byte write HADDR=0x13, HWDATA=0xAB00_0000 -> be=1000, addr=4. Halfword write HADDR=0x16 -> be=1100.
- Errors, ADDR_WIDTH=10:
  - halfword at 0x11 -> ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), sram_cs never high;
  - word at 0x1000 -> same response;
  - HSIZE=011 -> same response.
- Pipelined and idle, WAIT_STATES=0:
  - write 0x20 followed immediately by read 0x20 -> write strobe in the cycle after the write address; read strobe the next cycle; HRDATA equals the written data one cycle later;
  - HTRANS=00 -> zero-wait OKAY.
- Reset mid-operation, WAIT_STATES=3: assert HRESET during the second WAIT cycle of a write to 0x40 -> sram_we never asserted; HREADYOUT=1 the cycle after reset; a read of 0x40 returns the old data.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-lite slave fronting a single-port synchronous SRAM
// Decodes size/lanes, inserts WAIT_STATES data-phase cycles, answers illegal accesses with a two-cycle ERROR.
module ahb_sram_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic [1:0]            HRESP,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_ACC, S_WR_ACC, S_ERR1, S_ERR2
  } state_t;

  localparam logic [2:0]  WR_WAIT = 3'(WAIT_STATES);
  // Reads need at least one wait cycle: the SRAM returns data the cycle after the strobe.
  localparam logic [2:0]  RD_WAIT = (WAIT_STATES == 0) ? 3'd1 : 3'(WAIT_STATES);
  localparam logic [32:0] CAP     = 33'd4 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;
  logic                  r_write;
  logic [3:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic [31:0] w_off;
  logic        w_ready_state;
  logic        w_accept;
  logic        w_illegal;
  logic [3:0]  w_be;
  logic        w_rd_strobe;
  logic        w_unused;

  assign w_unused      = ^HBURST;
  assign w_off         = HADDR - BASE_ADDR;
  assign w_ready_state = r_state inside {S_IDLE, S_RD_ACC, S_WR_ACC, S_ERR2};
  assign w_accept      = w_ready_state & HSEL & HREADY & HTRANS[1];
  assign w_illegal     = (HSIZE > 3'b010)
                       | ((HSIZE == 3'b001) & HADDR[0])
                       | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                       | ({1'b0, w_off} >= CAP);

  always_comb begin
    w_be = 4'b1111;
    case (HSIZE[1:0])
      2'b00:   w_be = 4'b0001 << HADDR[1:0];
      2'b01:   w_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_be    <= 4'b0000;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= HWRITE;
        r_be    <= w_be;
        r_addr  <= w_off[ADDR_WIDTH+1:2];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 3'd1) w_state_nxt = r_write ? S_WR_ACC : S_RD_ACC;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_state_nxt = S_ERR1;
          end else if (HWRITE) begin
            if (WR_WAIT == 3'd0) begin
              w_state_nxt = S_WR_ACC;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = WR_WAIT;
            end
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = RD_WAIT;
          end
        end
      end
    endcase
  end

  // The counter still holds its load value only in the first WAIT cycle.
  assign w_rd_strobe = (r_state == S_WAIT) & ~r_write & (r_cnt == RD_WAIT);

  assign HREADYOUT  = HRESET | w_ready_state;
  assign HRESP      = (~HRESET & (r_state inside {S_ERR1, S_ERR2})) ? 2'b01 : 2'b00;
  assign HRDATA     = (~HRESET & (r_state == S_RD_ACC)) ? sram_rdata : 32'h0;
  assign sram_cs    = ~HRESET & (w_rd_strobe | (r_state == S_WR_ACC));
  assign sram_we    = ~HRESET & (r_state == S_WR_ACC);
  assign sram_be    = w_rd_strobe ? 4'b1111 : ((r_state == S_WR_ACC) ? r_be : 4'b0000);
  assign sram_addr  = r_addr;
  assign sram_wdata = HWDATA;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard bench for ahb_sram_slave at WAIT_STATES 1, 0 and 3
module tb_ahb_sram_slave;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          hreset;
  logic          mem_clr;
  logic [NI-1:0] hsel;
  logic [31:0]   haddr;
  logic [31:0]   hwdata;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic          hready;
  logic [NI-1:0] hreadyout;
  logic [NI-1:0] cs;
  logic [NI-1:0] we;
  logic [31:0]   hrdata [NI];
  logic [1:0]    hresp  [NI];
  logic [3:0]    be     [NI];
  logic [9:0]    saddr  [NI];
  logic [31:0]   swdata [NI];
  logic [31:0]   srdata [NI];

  assign hready = &hreadyout;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [31:0] mem [1024];

    ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) u_dut (
      .HCLK(clk), .HRESET(hreset), .HSEL(hsel[g]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hreadyout[g]), .HRDATA(hrdata[g]), .HRESP(hresp[g]),
      .sram_cs(cs[g]), .sram_we(we[g]), .sram_be(be[g]), .sram_addr(saddr[g]),
      .sram_wdata(swdata[g]), .sram_rdata(srdata[g])
    );

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else begin
        if (cs[g] && we[g])
          for (int b = 0; b < 4; b++)
            if (be[g][b]) mem[saddr[g]][8*b +: 8] <= swdata[g][8*b +: 8];
        if (cs[g] && !we[g]) srdata[g] <= mem[saddr[g]];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { int inst; logic [9:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
  typedef struct { logic err; logic rd; logic [31:0] rdata; int waits; } rsp_t;
  wr_t  wq [$];
  rsp_t rq [$];
  int   n_rd [NI] = '{default: 0};
  int   n_wr [NI] = '{default: 0};

  // SRAM-side monitor: every write strobe must match a queued expectation.
  always @(negedge clk) begin
    wr_t e;
    for (int s = 0; s < NI; s++) begin
      if (cs[s] && we[s]) begin
        n_wr[s]++;
        if (wq.size() == 0) begin
          check("wr_unexpected", 32'(s), 32'hFFFF_FFFF);
        end else begin
          e = wq.pop_front();
          check("wr_inst", 32'(s), 32'(e.inst));
          check("wr_addr", 32'(saddr[s]), 32'(e.addr));
          check("wr_be", 32'(be[s]), 32'(e.be));
          check("wr_data", swdata[s], e.data);
        end
      end
      if (cs[s] && !we[s]) begin
        n_rd[s]++;
        check("rd_be", 32'(be[s]), 32'hF);
      end
    end
  end

  function automatic int ws_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
  endfunction

  task automatic push_wr(input int s, input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_t w;
    w.inst = s; w.addr = a; w.be = b; w.data = d;
    wq.push_back(w);
  endtask

  task automatic xfer(input int s, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [9:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_rd, input logic err);
    rsp_t r;
    rsp_t e;
    int   waits;
    r.err   = err;
    r.rd    = !wr;
    r.rdata = exp_rd;
    r.waits = err ? 1 : (wr ? ws_of(s) : ((ws_of(s) == 0) ? 1 : ws_of(s)));
    rq.push_back(r);
    if (wr && !err) push_wr(s, exp_addr, exp_be, wd);
    hsel[s] = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
    @(posedge clk); #1;
    hsel = '0; htrans = 2'b00; hwdata = wd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (hreadyout[s]) break;
      waits++;
      check("wait_resp", 32'(hresp[s]), r.err ? 32'd1 : 32'd0);
      if (r.rd) check("wait_rdata", hrdata[s], 32'h0);
      if (waits > 16) begin
        check("xfer_timeout", 32'(waits), 32'd16);
        break;
      end
    end
    e = rq.pop_front();
    check("xfer_waits", 32'(waits), 32'(e.waits));
    check("xfer_resp", 32'(hresp[s]), e.err ? 32'd1 : 32'd0);
    if (e.rd && !e.err) check("xfer_rdata", hrdata[s], e.rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t r;
    int   snap_rd;
    int   snap_wr;
    hreset = 1'b1; mem_clr = 1'b1; hsel = '0; haddr = 32'h0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b000; hwdata = 32'h0;
    @(posedge clk); #1;
    mem_clr = 1'b0;

    // Reset held with an active request.
    hsel[0] = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010;
    repeat (2) begin
      @(negedge clk);
      check("rst_hreadyout", 32'(hreadyout[0]), 32'd1);
      check("rst_hresp", 32'(hresp[0]), 32'd0);
      check("rst_hrdata", hrdata[0], 32'h0);
      check("rst_cs", 32'(cs[0]), 32'd0);
      @(posedge clk); #1;
    end
    hreset = 1'b0; hsel = '0; htrans = 2'b00;
    @(posedge clk); #1;

    // WAIT_STATES=1: word, byte and halfword traffic.
    xfer(0, 32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF, 10'd4, 4'b1111, 32'h0, 1'b0);
    xfer(0, 32'h10, 1'b0, 3'b010, 32'h0, 10'd4, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 32'h13, 1'b1, 3'b000, 32'hAB00_0000, 10'd4, 4'b1000, 32'h0, 1'b0);
    xfer(0, 32'h16, 1'b1, 3'b001, 32'h1234_0000, 10'd5, 4'b1100, 32'h0, 1'b0);
    xfer(0, 32'h11, 1'b1, 3'b000, 32'h0000_5A00, 10'd4, 4'b0010, 32'h0, 1'b0);
    xfer(0, 32'h10, 1'b0, 3'b010, 32'h0, 10'd4, 4'b1111, 32'hABAD_5AEF, 1'b0);
    xfer(0, 32'h14, 1'b0, 3'b010, 32'h0, 10'd5, 4'b1111, 32'h1234_0000, 1'b0);
    xfer(0, 32'hFFC, 1'b1, 3'b010, 32'h0F0F_F0F0, 10'd1023, 4'b1111, 32'h0, 1'b0);
    xfer(0, 32'hFFC, 1'b0, 3'b010, 32'h0, 10'd1023, 4'b1111, 32'h0F0F_F0F0, 1'b0);

    // Illegal accesses: no SRAM activity at all.
    snap_rd = n_rd[0]; snap_wr = n_wr[0];
    xfer(0, 32'h11, 1'b1, 3'b001, 32'h0, 10'd0, 4'b0000, 32'h0, 1'b1);
    xfer(0, 32'h1000, 1'b0, 3'b010, 32'h0, 10'd0, 4'b0000, 32'h0, 1'b1);
    xfer(0, 32'h10, 1'b0, 3'b011, 32'h0, 10'd0, 4'b0000, 32'h0, 1'b1);
    xfer(0, 32'h12, 1'b1, 3'b010, 32'h0, 10'd0, 4'b0000, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("err_rd_strobes", 32'(n_rd[0]), 32'(snap_rd));
    check("err_wr_strobes", 32'(n_wr[0]), 32'(snap_wr));

    // WAIT_STATES=0: write then read of the same word with no idle cycle.
    push_wr(1, 10'd8, 4'b1111, 32'hCAFE_F00D);
    hsel[1] = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'hCAFE_F00D; hwrite = 1'b0;
    r.err = 1'b0; r.rd = 1'b1; r.rdata = 32'hCAFE_F00D; r.waits = 1;
    rq.push_back(r);
    @(negedge clk);
    check("pl_wr_ready", 32'(hreadyout[1]), 32'd1);
    check("pl_wr_cs", 32'(cs[1]), 32'd1);
    check("pl_wr_we", 32'(we[1]), 32'd1);
    @(posedge clk); #1;
    hsel = '0; htrans = 2'b00;
    @(negedge clk);
    check("pl_rd_ready", 32'(hreadyout[1]), 32'd0);
    check("pl_rd_cs", 32'(cs[1]), 32'd1);
    check("pl_rd_we", 32'(we[1]), 32'd0);
    check("pl_rd_addr", 32'(saddr[1]), 32'd8);
    @(posedge clk); #1;
    @(negedge clk);
    r = rq.pop_front();
    check("pl_rdata_ready", 32'(hreadyout[1]), 32'd1);
    check("pl_rdata", hrdata[1], r.rdata);
    check("pl_resp", 32'(hresp[1]), 32'd0);
    @(posedge clk); #1;

    // IDLE transfers to a selected slave: zero-wait OKAY, no SRAM access.
    hsel[1] = 1'b1; htrans = 2'b00; haddr = 32'h24; hwrite = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ready", 32'(hreadyout[1]), 32'd1);
      check("idle_resp", 32'(hresp[1]), 32'd0);
      check("idle_cs", 32'(cs[1]), 32'd0);
      @(posedge clk); #1;
    end
    hsel = '0;
    xfer(1, 32'h21, 1'b0, 3'b000, 32'h0, 10'd8, 4'b1111, 32'hCAFE_F00D, 1'b0);

    // WAIT_STATES=3: reset lands in the second wait cycle of a write.
    xfer(2, 32'h40, 1'b1, 3'b010, 32'h1111_2222, 10'd16, 4'b1111, 32'h0, 1'b0);
    snap_wr = n_wr[2];
    hsel[2] = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = '0; htrans = 2'b00; hwdata = 32'h9999_9999;
    @(negedge clk);
    check("mid_wait1_ready", 32'(hreadyout[2]), 32'd0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(hreadyout[2]), 32'd1);
    check("mid_rst_cs", 32'(cs[2]), 32'd0);
    check("mid_rst_we", 32'(we[2]), 32'd0);
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    check("mid_after_ready", 32'(hreadyout[2]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("mid_wr_strobes", 32'(n_wr[2]), 32'(snap_wr));
    xfer(2, 32'h40, 1'b0, 3'b010, 32'h0, 10'd16, 4'b1111, 32'h1111_2222, 1'b0);

    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
